// File: rtl/darkriscv_dmem_bridge_if.sv
// rtl/darkriscv_dmem_bridge_if.sv - darkriscv data-bus bundle between core (master) and memory bridge (slave)
// Optional DMEM_ACCESS_COUNT_EN adds the RDCNT/WRCNT access counters.
interface darkriscv_dmem_bridge_if;
    logic        DAS;
    logic        DRD;
    logic        DWR;
    logic [2:0]  DLEN;
    logic [31:0] DADDR;
    logic [31:0] DATAO;
    logic [31:0] DATAI;
    logic        HLT;
    logic        ERR;
`ifdef DMEM_ACCESS_COUNT_EN
    logic [31:0] RDCNT;
    logic [31:0] WRCNT;

    modport master (
        output DAS, DRD, DWR, DLEN, DADDR, DATAO,
        input  DATAI, HLT, ERR, RDCNT, WRCNT
    );
    modport slave (
        input  DAS, DRD, DWR, DLEN, DADDR, DATAO,
        output DATAI, HLT, ERR, RDCNT, WRCNT
    );
`else
    modport master (
        output DAS, DRD, DWR, DLEN, DADDR, DATAO,
        input  DATAI, HLT, ERR
    );
    modport slave (
        input  DAS, DRD, DWR, DLEN, DADDR, DATAO,
        output DATAI, HLT, ERR
    );
`endif
endinterface

// File: rtl/darkriscv_dmem_bridge.sv
// rtl/darkriscv_dmem_bridge.sv - darkriscv data-memory responder with wait states, lane writes and sticky error
// Optional DMEM_ACCESS_COUNT_EN adds saturating good-read/good-write counters.
module darkriscv_dmem_bridge #(
    parameter int          ADDR_W      = 10,
    parameter logic [31:0] BASE        = 32'h0000_1000,
    parameter int          WAIT_CYCLES = 1
) (
    input logic                      CLK,
    input logic                      RES,
    darkriscv_dmem_bridge_if.slave   bus
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("darkriscv_dmem_bridge: WAIT_CYCLES must be 0..15");
    end
    if (BASE[ADDR_W+1:0] != '0) begin : g_bad_base
        $error("darkriscv_dmem_bridge: BASE not aligned to window size");
    end

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [2:0]          dlen_q, dlen_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [31:0]         datai_q;
    logic                err_q;
    logic                hit;
    logic                hlt;
    logic                do_op;
    logic                acc_err;
    logic [3:0]          lane_en;
    logic [31:0]         mem_q [DEPTH];

    assign hit = bus.DAS & (bus.DRD | bus.DWR) &
                 (bus.DADDR[31:ADDR_W+2] == BASE[31:ADDR_W+2]);

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            dlen_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dlen_q  <= dlen_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // Request fields are captured only in IDLE so the core may change them while stalled.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dlen_d  = dlen_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        hlt     = 1'b0;
        do_op   = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    addr_d  = bus.DADDR[ADDR_W+1:0];
                    wdata_d = bus.DATAO;
                    dlen_d  = bus.DLEN;
                    rd_d    = bus.DRD;
                    wr_d    = bus.DWR;
                    cnt_d   = WAIT_INIT;
                    state_d = BUSY;
                    hlt     = 1'b1;
                end
            end
            BUSY: begin
                hlt = 1'b1;
                if (cnt_q == 4'd0) begin
                    do_op   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (RES) begin
            state_d = IDLE;
            hlt     = 1'b0;
            do_op   = 1'b0;
        end
    end

    always_comb begin
        acc_err = !(dlen_q == 3'b001 || dlen_q == 3'b010 || dlen_q == 3'b100) ||
                  (rd_q & wr_q) ||
                  (dlen_q == 3'b010 && addr_q[0]) ||
                  (dlen_q == 3'b100 && addr_q[1:0] != 2'd0);
        case (dlen_q)
            3'b001:  lane_en = 4'b0001 << addr_q[1:0];
            3'b010:  lane_en = 4'b0011 << addr_q[1:0];
            3'b100:  lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (do_op && wr_q && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem_q[addr_q[ADDR_W+1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // Faulting reads return zero so the core never sees data from a rejected access.
    always_ff @(posedge CLK) begin
        if (RES) begin
            datai_q <= '0;
            err_q   <= 1'b0;
        end else if (do_op) begin
            if (acc_err) begin
                err_q <= 1'b1;
            end
            if (rd_q) begin
                datai_q <= acc_err ? 32'h0 : mem_q[addr_q[ADDR_W+1:2]];
            end
        end
    end

`ifdef DMEM_ACCESS_COUNT_EN
    logic [31:0] rdcnt_q;
    logic [31:0] wrcnt_q;

    always_ff @(posedge CLK) begin
        if (RES) begin
            rdcnt_q <= '0;
            wrcnt_q <= '0;
        end else if (do_op && !acc_err) begin
            if (rd_q && rdcnt_q != 32'hFFFF_FFFF) begin
                rdcnt_q <= rdcnt_q + 32'd1;
            end
            if (wr_q && wrcnt_q != 32'hFFFF_FFFF) begin
                wrcnt_q <= wrcnt_q + 32'd1;
            end
        end
    end

    assign bus.RDCNT = rdcnt_q;
    assign bus.WRCNT = wrcnt_q;
`endif

    assign bus.HLT   = hlt;
    assign bus.DATAI = datai_q;
    assign bus.ERR   = err_q;

endmodule

// File: tb/tb_darkriscv_dmem_bridge.sv
// tb/tb_darkriscv_dmem_bridge.sv - randomized self-checking bench for darkriscv_dmem_bridge
// Two instances (1 and 3 wait states) share one stimulus path selected by sel.
module tb_darkriscv_dmem_bridge;

    logic        clk = 1'b0;
    logic        res;
    logic        das, drd, dwr;
    logic [2:0]  dlen;
    logic [31:0] daddr, datao;
    int          sel;
    logic        hlt, errs;
    logic [31:0] datai;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] mem_m [2][16];
    bit          err_m [2];
    int unsigned rdc_m [2];
    int unsigned wrc_m [2];

    always #5 clk = ~clk;

    darkriscv_dmem_bridge_if bus1 ();
    darkriscv_dmem_bridge_if bus3 ();

    assign bus1.DAS   = das & (sel == 0);
    assign bus3.DAS   = das & (sel == 1);
    assign bus1.DRD   = drd;
    assign bus3.DRD   = drd;
    assign bus1.DWR   = dwr;
    assign bus3.DWR   = dwr;
    assign bus1.DLEN  = dlen;
    assign bus3.DLEN  = dlen;
    assign bus1.DADDR = daddr;
    assign bus3.DADDR = daddr;
    assign bus1.DATAO = datao;
    assign bus3.DATAO = datao;

    assign hlt   = (sel == 0) ? bus1.HLT   : bus3.HLT;
    assign errs  = (sel == 0) ? bus1.ERR   : bus3.ERR;
    assign datai = (sel == 0) ? bus1.DATAI : bus3.DATAI;

    darkriscv_dmem_bridge #(.ADDR_W(10), .BASE(32'h0000_1000), .WAIT_CYCLES(1)) u_dut1 (
        .CLK (clk),
        .RES (res),
        .bus (bus1)
    );

    darkriscv_dmem_bridge #(.ADDR_W(10), .BASE(32'h0000_1000), .WAIT_CYCLES(3)) u_dut3 (
        .CLK (clk),
        .RES (res),
        .bus (bus3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One core access; the model decides hit, error, latency and data from address arithmetic.
    task automatic do_acc(input int s, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] len, input logic r, input logic w,
                          output logic [31:0] rdata);
        int   size, hc, widx, lane, wait_n;
        bit   hit, bad;
        logic [31:0] exp_rd;
        wait_n = (s == 0) ? 1 : 3;
        hit    = (a >= 32'h1000) && (a < 32'h2000) && (r || w);
        widx   = int'((a - 32'h1000) >> 2);
        size   = (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : (len == 3'd4) ? 4 : 0;
        bad    = (size == 0) || (r && w) || ((a % size) != 0);
        @(negedge clk);
        sel = s; das = 1'b1; drd = r; dwr = w; dlen = len; daddr = a; datao = wd;
        hc = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (!hlt) break;
            hc++;
            @(negedge clk);
            daddr = $urandom; datao = $urandom; dlen = 3'($urandom);
        end
        rdata  = datai;
        exp_rd = 32'h0;
        if (hit) begin
            if (bad) begin
                err_m[s] = 1'b1;
            end else begin
                exp_rd = mem_m[s][widx];
                if (w) begin
                    for (int b = 0; b < size; b++) begin
                        lane = (a % 4) + b;
                        mem_m[s][widx][8*lane +: 8] = wd[8*lane +: 8];
                    end
                    wrc_m[s]++;
                end
                if (r) rdc_m[s]++;
            end
        end
        check("hlt_cycles", 32'(hc), hit ? 32'(wait_n + 2) : 32'd0);
        check("err", {31'b0, errs}, {31'b0, err_m[s]});
        if (hit && r) check("rdata", rdata, exp_rd);
`ifdef DMEM_ACCESS_COUNT_EN
        check("rdcnt", (s == 0) ? bus1.RDCNT : bus3.RDCNT, rdc_m[s]);
        check("wrcnt", (s == 0) ? bus1.WRCNT : bus3.WRCNT, wrc_m[s]);
`endif
        @(negedge clk);
        das = 1'b0; drd = 1'b0; dwr = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, saved;
        logic [2:0]  len;
        logic [31:0] a;
        logic        r, w;
        int          pick, s;

        res = 1'b1; sel = 0;
        das = 1'b1; drd = 1'b1; dwr = 1'b0; dlen = 3'b100; daddr = 32'h1000; datao = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_hlt1", {31'b0, bus1.HLT}, 32'd0);
        check("rst_hlt3", {31'b0, bus3.HLT}, 32'd0);
        check("rst_datai1", bus1.DATAI, 32'h0);
        check("rst_datai3", bus3.DATAI, 32'h0);
        check("rst_err1", {31'b0, bus1.ERR}, 32'd0);
        check("rst_err3", {31'b0, bus3.ERR}, 32'd0);
`ifdef DMEM_ACCESS_COUNT_EN
        check("rst_rdcnt", bus1.RDCNT, 32'h0);
        check("rst_wrcnt", bus1.WRCNT, 32'h0);
`endif
        das = 1'b0; drd = 1'b0;
        @(negedge clk);
        res = 1'b0;
        for (int i = 0; i < 2; i++) begin
            err_m[i] = 1'b0; rdc_m[i] = 0; wrc_m[i] = 0;
        end

        for (int i = 0; i < 2; i++)
            for (int wi = 0; wi < 16; wi++)
                do_acc(i, 32'h1000 + 32'(wi * 4), $urandom, 3'b100, 1'b0, 1'b1, rd);

        do_acc(0, 32'h1004, 32'hDEAD_BEEF, 3'b100, 1'b0, 1'b1, rd);
        do_acc(0, 32'h1004, 32'h0, 3'b100, 1'b1, 1'b0, rd);
        check("dir_word_rd", rd, 32'hDEAD_BEEF);

        do_acc(0, 32'h1008, 32'h0, 3'b100, 1'b0, 1'b1, rd);
        do_acc(0, 32'h1009, 32'h0000_AA00, 3'b001, 1'b0, 1'b1, rd);
        do_acc(0, 32'h100A, 32'h1234_0000, 3'b010, 1'b0, 1'b1, rd);
        do_acc(0, 32'h1008, 32'h0, 3'b100, 1'b1, 1'b0, rd);
        check("dir_lanes", rd, 32'h1234_AA00);

        do_acc(0, 32'h0000_0040, 32'h0, 3'b100, 1'b1, 1'b0, rd);
        check("miss_keep", rd, 32'h1234_AA00);
        check("miss_err", {31'b0, errs}, 32'd0);

        saved = mem_m[0][4];
        do_acc(0, 32'h1012, 32'hFFFF_FFFF, 3'b100, 1'b0, 1'b1, rd);
        check("mis_err", {31'b0, errs}, 32'd1);
        do_acc(0, 32'h1010, 32'h0, 3'b100, 1'b1, 1'b0, rd);
        check("mis_nowrite", rd, saved);
        do_acc(0, 32'h1012, 32'h0, 3'b100, 1'b1, 1'b0, rd);
        check("mis_rd_zero", rd, 32'h0);
        check("err_sticky", {31'b0, errs}, 32'd1);

        saved = mem_m[1][8];
        @(negedge clk);
        sel = 1; das = 1'b1; dwr = 1'b1; drd = 1'b0; dlen = 3'b100;
        daddr = 32'h1020; datao = ~saved;
        #1 check("rst_claim_hlt", {31'b0, hlt}, 32'd1);
        @(negedge clk);
        das = 1'b0; dwr = 1'b0;
        #1 check("rst_busy_hlt", {31'b0, hlt}, 32'd1);
        @(negedge clk);
        res = 1'b1;
        #1 check("rst_mid_hlt", {31'b0, hlt}, 32'd0);
        @(negedge clk);
        res = 1'b0;
        #1 check("rst_idle_hlt", {31'b0, hlt}, 32'd0);
        err_m[1] = 1'b0; rdc_m[1] = 0; wrc_m[1] = 0;
        err_m[0] = 1'b0; rdc_m[0] = 0; wrc_m[0] = 0;
        do_acc(1, 32'h1020, 32'h0, 3'b100, 1'b1, 1'b0, rd);
        check("rst_dropped", rd, saved);

        for (int n = 0; n < 250; n++) begin
            s    = int'($urandom_range(0, 1));
            pick = int'($urandom_range(0, 19));
            r = (pick < 9) || (pick == 18);
            w = (pick >= 9 && pick < 18) || (pick == 18);
            if (pick == 19) begin r = 1'b0; w = 1'b0; end
            case ($urandom_range(0, 9))
                0:       len = 3'($urandom);
                1, 2, 3: len = 3'b001;
                4, 5, 6: len = 3'b010;
                default: len = 3'b100;
            endcase
            if ($urandom_range(0, 15) == 0)
                a = (($urandom_range(0, 1) == 0) ? 32'h0000_0000 : 32'h0000_2000) + 32'($urandom_range(0, 4095));
            else
                a = 32'h1000 + 32'($urandom_range(0, 63));
            do_acc(s, a, $urandom, len, r, w, rd);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/darkriscv_dmem_bridge.md
Name: darkriscv_dmem_bridge

Overview:
- Data-memory responder on the darkriscv core data bus; consumes DADDR/DATAO/DLEN/DRD/DWR/DAS and returns DATAI and HLT.
- Holds the core with HLT for a configurable number of wait states, performs byte/half/word writes through lane enables, and returns full 32-bit read words.
- Flags misaligned or illegal accesses on a sticky error output.
- Sits directly downstream of the core in the simulation top, replacing the ideal memory model.

Parameters:
- ADDR_W, 10, word-address width; internal RAM depth is 2**ADDR_W x 32 bits.
- BASE, 32'h0000_1000, window base; must be aligned to 4*2**ADDR_W.
- WAIT_CYCLES, 1, extra stall cycles per access (0..15).

Ports:
- CLK  in  1  clock, rising edge.
- RES  in  1  reset; synchronous and active-high.
- DAS  in  1  data address strobe.
- DRD  in  1  read request.
- DWR  in  1  write request.
- DLEN  in  3  access size, one-hot: 001 byte, 010 half, 100 word.
- DADDR  in  32  byte address.
- DATAO  in  32  write data, lane-aligned by the core.
- DATAI  out  32  read data, full word, registered.
- HLT  out  1  stall to core.
- ERR  out  1  sticky access error.

Behaviour:
- Reset values: state IDLE, HLT=0, DATAI=0, ERR=0. RAM contents are not reset.
- Claim condition: hit = DAS & (DRD|DWR) & (DADDR[31:ADDR_W+2] == BASE[31:ADDR_W+2]). Non-hit accesses are ignored: HLT=0, DATAI unchanged.
- States:
  - IDLE: on hit, latch address, data, DLEN and R/W, load counter=WAIT_CYCLES, go to BUSY.
  - BUSY: decrement the counter each cycle; when it reaches 0, perform the RAM operation and go to DONE.
  - DONE: go to IDLE unconditionally.
- HLT is combinational: (IDLE & hit) | BUSY. It is low in DONE and low while RES=1.
- Latency: a request first seen in cycle t is stalled for cycles t..t+WAIT_CYCLES+1. DATAI is valid and HLT=0 in cycle t+WAIT_CYCLES+2 (DONE).
- Back-to-back requests: a new request can be claimed only from IDLE, so there is a 1-cycle minimum gap after DONE. The core has advanced by then.
- Lane enables:
  - byte: 1<<DADDR[1:0].
  - half: 4'b0011<<DADDR[1:0].
  - word: 4'b1111.
  - Only enabled lanes of the RAM word are modified.
- Reads: DATAI is the unmodified 32-bit word at DADDR[ADDR_W+1:2]. The core extracts lanes itself.
- Error cases set ERR=1 (sticky until RES):
  - half access with DADDR[0]=1;
  - word access with DADDR[1:0]!=0;
  - DLEN not one-hot;
  - DRD & DWR both set.
- An error access still completes with normal latency, the write is suppressed, and the read returns DATAI=32'h0.
- Core inputs are sampled only in IDLE; changes during BUSY are ignored.
- Reset mid-operation: on RES=1 the next state is IDLE, and a pending write is dropped (no RAM modification).
- The WAIT_CYCLES counter is 4 bits; values >15 are rejected by an elaboration-time $error.

Optional Feature:
- DMEM_ACCESS_COUNT_EN adds two outputs: RDCNT (32) and WRCNT (32).
- Each counter increments on the DONE cycle of a successful (non-error) read or write respectively.
- The counters saturate at 32'hFFFF_FFFF and clear to 0 on RES.
- Without the macro, the ports and the counter logic are absent; behaviour is otherwise identical.

Test Plan:
- Word write then read, WAIT_CYCLES=1: write DATAO=32'hDEAD_BEEF to 32'h1004, then read 32'h1004. Required: HLT high for exactly 3 cycles per access, DATAI=32'hDEADBEEF in the DONE cycle, ERR=0.
- Byte writes into a word preloaded with 32'h0000_0000: byte 8'hAA at 32'h1009 and half 16'h1234 at 32'h100A. Reading 32'h1008 returns 32'h1234_AA00.
- Misaligned word write of 32'hFFFF_FFFF to 32'h1012: ERR rises and stays 1, the word at 32'h1010 is unchanged, and a read of 32'h1012 returns 32'h0.
- Out-of-window read at 32'h0000_0040: HLT stays 0, DATAI unchanged, ERR=0.
- RES asserted during BUSY of a write to 32'h1020 with WAIT_CYCLES=3: the next cycle is IDLE with HLT=0, and a subsequent read of 32'h1020 returns its prior value.
- With DMEM_ACCESS_COUNT_EN: 3 good reads, 2 good writes and 1 misaligned write give RDCNT=3 and WRCNT=2. RES clears both to 0.
